// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result transmitter.
//   tdc_tx_state_t : per-byte serializer state (IDLE, START, DATA, STOP)
//   SYNC_BYTE      : first byte of every result frame
//   num_bytes()    : payload bytes needed for a given number of TDC stages
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tdc_tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // ceil(stages / 8)
  function automatic int unsigned num_bytes(input int unsigned stages);
    return (stages + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/tdc_uart_byte_tx.sv
// 8N1 byte serializer: one start bit, 8 data bits LSB-first, one stop bit,
// each held CLKS_PER_BIT cycles. A start request seen in the last cycle of a
// stop bit chains straight into the next start bit with no idle gap.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start_i       : request to send data_i (honoured in IDLE or at stop end)
//   data_i        : byte to send, sampled together with start_i
//   done_c_o      : combinational, high in the final cycle of the stop bit
//   tx_o          : registered serial line, idles high
module tdc_uart_byte_tx
  import tdc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       done_c_o,
  output logic       tx_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  tdc_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end_c;

  assign bit_end_c = (baud_q == BIT_END);
  assign done_c_o  = (state_q == STOP) && bit_end_c;
  assign tx_o      = tx_q;

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line value for the coming cycle.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;

    // Baud counter reloads at every bit boundary so bytes never drift.
    if (state_q != IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_i) begin
          state_d = START;
          shreg_d = data_i;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (start_i) begin
            state_d = START;
            shreg_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tdc_result_tx.sv
// TDC result transmitter: accepts a NUM_STAGES-bit snapshot on a valid/ready
// handshake and sends it as 8N1 bytes: SYNC_BYTE, then the zero-padded
// payload LSB byte first. With TDC_TX_CHECKSUM_EN defined, an XOR of the
// payload bytes follows the payload.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   result_valid  : result_data holds a result to send
//   result_data   : TDC stage snapshot, bit 0 = stage 0
//   result_ready  : registered, high only while idle
//   uart_tx       : registered serial line, idles high
//   busy          : registered, high while a frame is in flight
module tdc_result_tx
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 10,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  result_valid,
  input  logic [NUM_STAGES-1:0] result_data,
  output logic                  result_ready,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int unsigned NB    = num_bytes(NUM_STAGES);
  localparam int unsigned PAD_W = NB * 8;
`ifdef TDC_TX_CHECKSUM_EN
  localparam int unsigned LAST_IDX = NB + 1;
`else
  localparam int unsigned LAST_IDX = NB;
`endif
  localparam int unsigned IDX_W = $clog2(LAST_IDX + 1);

  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAD_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] nxt_idx_c;
  logic [7:0]       payload_c;
  logic [7:0]       byte_c;
  logic             start_c;
  logic             done_c;
  logic             hs_c;

  assign hs_c         = result_valid && ready_q;
  assign result_ready = ready_q;
  assign busy         = busy_q;

  // Frame sequencing registers and capture shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Start a frame on handshake; chain the next byte at each stop-bit end.
  always_comb begin
    busy_d    = busy_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    start_c   = 1'b0;
    nxt_idx_c = idx_q + IDX_W'(1);

    if (!busy_q) begin
      if (hs_c) begin
        busy_d    = 1'b1;
        idx_d     = '0;
        shadow_d  = PAD_W'(result_data);
        start_c   = 1'b1;
        nxt_idx_c = '0;
      end
    end else if (done_c) begin
      if (idx_q == IDX_W'(LAST_IDX)) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        start_c = 1'b1;
        idx_d   = idx_q + IDX_W'(1);
      end
    end

    ready_d = !busy_d;
  end

  // Payload byte k (1-based frame index) is shadow byte k-1.
  always_comb begin
    payload_c = 8'd0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (nxt_idx_c == IDX_W'(i + 1)) begin
        payload_c = shadow_q[8*i +: 8];
      end
    end
  end

`ifdef TDC_TX_CHECKSUM_EN
  logic [7:0] chk_c;

  // XOR of payload bytes only; the sync byte is not covered.
  always_comb begin
    chk_c = 8'd0;
    for (int unsigned i = 0; i < NB; i++) begin
      chk_c = chk_c ^ shadow_q[8*i +: 8];
    end
  end

  always_comb begin
    if (nxt_idx_c == '0) begin
      byte_c = SYNC_BYTE;
    end else if (nxt_idx_c == IDX_W'(LAST_IDX)) begin
      byte_c = chk_c;
    end else begin
      byte_c = payload_c;
    end
  end
`else
  always_comb begin
    if (nxt_idx_c == '0) begin
      byte_c = SYNC_BYTE;
    end else begin
      byte_c = payload_c;
    end
  end
`endif

  tdc_uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_c),
    .data_i   (byte_c),
    .done_c_o (done_c),
    .tx_o     (uart_tx)
  );

endmodule

// File: tb/tb_tdc_result_tx.sv
// Testbench for tdc_result_tx (NUM_STAGES=10, CLKS_PER_BIT=4). Expected line
// waveforms come from a byte-list model of the frame format.
module tb_tdc_result_tx;

  localparam int NS  = 10;
  localparam int CPB = 4;
  localparam int NB  = (NS + 7) / 8;
`ifdef TDC_TX_CHECKSUM_EN
  localparam int NBYTES = NB + 2;
`else
  localparam int NBYTES = NB + 1;
`endif
  localparam int FRAME = NBYTES * 10 * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          result_valid = 1'b0;
  logic [NS-1:0] result_data = '0;
  logic          result_ready;
  logic          uart_tx;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;
  bit exp_bits[$];

  always #5 clk = ~clk;

  tdc_result_tx #(
    .NUM_STAGES   (NS),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_ready (result_ready),
    .uart_tx      (uart_tx),
    .busy         (busy)
  );

  always @(posedge clk) begin
    if (reset_n && result_valid && result_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame = sync, zero-padded payload bytes LSB first, optional XOR; 8N1 bits.
  function automatic void build_frame(input logic [NS-1:0] val);
    logic [7:0]  bytes[$];
    logic [7:0]  chk;
    logic [7:0]  cur;
    logic [63:0] wide;
    chk  = 8'd0;
    wide = 64'(val);
    bytes.push_back(8'hA5);
    for (int b = 0; b < NB; b++) begin
      cur = wide[8*b +: 8];
      bytes.push_back(cur);
      chk = chk ^ cur;
    end
`ifdef TDC_TX_CHECKSUM_EN
    bytes.push_back(chk);
`endif
    exp_bits.delete();
    foreach (bytes[i]) begin
      cur = bytes[i];
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_bits.push_back(cur[k]);
      exp_bits.push_back(1'b1);
    end
  endfunction

  // Called at a negedge. Checks {uart_tx,busy,result_ready} every cycle of
  // the frame, then the ready cycle. abort_at >= 0 pulses reset in that cycle.
  task automatic send_frame(input logic [NS-1:0] val, input bit interfere, input int abort_at);
    int n;
    int hs0;
    n = 0;
    build_frame(val);
    result_data  = val;
    result_valid = 1'b1;
    while (!result_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!result_ready) begin
      check_eq("hs_timeout", 32'(result_ready), 32'd1);
      result_valid = 1'b0;
      return;
    end
    hs0 = hs_count;
    @(negedge clk);
    for (int j = 0; j < FRAME; j++) begin
      check_eq("frame", {uart_tx, busy, result_ready}, {exp_bits[j / CPB], 1'b1, 1'b0});
      if (j == abort_at) begin
        result_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_eq("rst_async", {uart_tx, busy, result_ready}, 3'b100);
        @(negedge clk);
        check_eq("rst_hold", {uart_tx, busy, result_ready}, 3'b100);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release", {uart_tx, busy, result_ready}, 3'b101);
        return;
      end
      if (!interfere || j == FRAME - 1) result_valid = 1'b0;
      if (interfere) result_data = NS'($urandom);
      @(negedge clk);
    end
    check_eq("ready_ret", {uart_tx, busy, result_ready}, 3'b101);
    check_eq("one_hs", 32'(hs_count - hs0), 32'd1);
  endtask

  initial begin
    int gap;
    logic [NS-1:0] val;

    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_state", {uart_tx, busy, result_ready}, 3'b100);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", {uart_tx, busy, result_ready}, 3'b101);
    repeat (5) begin
      @(negedge clk);
      check_eq("idle", {uart_tx, busy, result_ready}, 3'b101);
    end

    send_frame(10'h2B5, 1'b0, -1);
    send_frame(10'h3FF, 1'b0, -1);
    send_frame(10'h155, 1'b1, -1);
    send_frame(10'h2B5, 1'b0, 12 * CPB + 1);
    send_frame(10'h001, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        check_eq("idle_gap", {uart_tx, busy, result_ready}, 3'b101);
        @(negedge clk);
      end
      val = NS'($urandom);
      send_frame(val, 1'(($urandom_range(0, 1))), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
